// File: rtl/fixed_point_accumulator.sv
// Fixed-point group accumulator. Sums NumTerms consecutive signed products,
// then rounds half-up, shifts right by FracBits and saturates to OutWidth.
// The result sits in a registered valid/ready output stage. While a result
// is held, the input ready follows the downstream ready, so the next group
// can start on the same cycle the held result is consumed.
module fixed_point_accumulator #(
    parameter int InWidth  = 32,
    parameter int OutWidth = 16,
    parameter int FracBits = 8,
    parameter int NumTerms = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic [InWidth-1:0]  prod_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [OutWidth-1:0] sum_o,
    output logic                sat_o,
    input  logic                ready_i
);

    // Sized so that summing NumTerms products plus the rounding constant
    // cannot overflow.
    localparam int AccWidth = InWidth + $clog2(NumTerms + 1) + 1;
    localparam int CntWidth = $clog2(NumTerms + 1);

    localparam logic signed [AccWidth-1:0] MaxV =
        {{(AccWidth-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] MinV =
        {{(AccWidth-OutWidth+1){1'b1}}, {(OutWidth-1){1'b0}}};

    typedef enum logic {ACCUM, OUT} state_t;

    state_t                     r_state, w_state_nx;
    logic signed [AccWidth-1:0] r_acc, w_acc_nx;
    logic [CntWidth-1:0]        r_count, w_count_nx;
    logic [OutWidth-1:0]        r_sum, w_sum_nx;
    logic                       r_sat, w_sat_nx;

    logic                       w_accept;
    logic                       w_last;
    logic signed [AccWidth-1:0] w_term;
    logic signed [AccWidth-1:0] w_total;
    logic signed [AccWidth-1:0] w_round;
    logic [OutWidth-1:0]        w_sum;
    logic                       w_sat;

    // Ready is forced low during reset; while a result is held it is the
    // downstream ready, so a term is only taken when the slot frees up.
    assign ready_o  = reset_i && ((r_state == ACCUM) || ready_i);
    assign valid_o  = (r_state == OUT);
    assign sum_o    = r_sum;
    assign sat_o    = r_sat;

    assign w_accept = valid_i && ready_o;
    assign w_last   = (r_count == CntWidth'(NumTerms - 1));
    assign w_term   = {{(AccWidth-InWidth){prod_i[InWidth-1]}}, prod_i};
    // After a group closes, r_acc/r_count are already zero, so a term taken
    // in OUT naturally becomes term 0 of the next group.
    assign w_total  = r_acc + w_term;

    generate
        if (FracBits > 0) begin : g_round
            localparam logic signed [AccWidth-1:0] RndConst =
                AccWidth'(1) << (FracBits - 1);
            logic signed [AccWidth-1:0] w_biased;
            assign w_biased = w_total + RndConst;
            assign w_round  = w_biased >>> FracBits;
        end else begin : g_noround
            assign w_round = w_total;
        end
    endgenerate

    // Clamp the rounded sum into the signed OutWidth range.
    always_comb begin
        w_sum = w_round[OutWidth-1:0];
        w_sat = 1'b0;
        if (w_round > MaxV) begin
            w_sum = {1'b0, {(OutWidth-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_round < MinV) begin
            w_sum = {1'b1, {(OutWidth-1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    // Next-state: consume a held result, then fold in any accepted term.
    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_count_nx = r_count;
        w_sum_nx   = r_sum;
        w_sat_nx   = r_sat;
        if (r_state == OUT && ready_i) begin
            w_state_nx = ACCUM;
        end
        if (w_accept) begin
            if (w_last) begin
                w_acc_nx   = '0;
                w_count_nx = '0;
                w_sum_nx   = w_sum;
                w_sat_nx   = w_sat;
                w_state_nx = OUT;
            end else begin
                w_acc_nx   = w_total;
                w_count_nx = r_count + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_count <= w_count_nx;
            r_sum   <= w_sum_nx;
            r_sat   <= w_sat_nx;
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: directed test-plan sequences with
// literal expectations, then random traffic checked every cycle against a
// transaction-level model (group term list, pending-result slot).
module tb_fixed_point_accumulator;

    localparam int IW = 32;
    localparam int OW = 16;
    localparam int FB = 8;
    localparam int NT = 3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [IW-1:0] prod_i = '0;
    logic          ready_i = 1'b1;
    logic          ready_o, valid_o, sat_o;
    logic [OW-1:0] sum_o;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    fixed_point_accumulator #(
        .InWidth(IW), .OutWidth(OW), .FracBits(FB), .NumTerms(NT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .prod_i(prod_i),
        .ready_o(ready_o), .valid_o(valid_o), .sum_o(sum_o), .sat_o(sat_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic longint rnd_shift(input longint s);
        if (FB == 0) return s;
        return (s + (longint'(1) << (FB - 1))) >>> FB;
    endfunction

    function automatic longint clamp(input longint r);
        longint mx = (longint'(1) << (OW - 1)) - 1;
        longint mn = -(longint'(1) << (OW - 1));
        if (r > mx) return mx;
        if (r < mn) return mn;
        return r;
    endfunction

    function automatic bit is_sat(input longint r);
        return clamp(r) != r;
    endfunction

    longint grp_sum = 0;
    int     grp_n   = 0;
    bit     has_res = 1'b0;
    longint res     = 0;   // as signed OutWidth value
    bit     res_sat = 1'b0;

    function automatic bit model_ready();
        return reset_i && (!has_res || ready_i);
    endfunction

    // Advance the model on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        bit take;
        if (!reset_i) begin
            grp_sum = 0; grp_n = 0; has_res = 1'b0; res = 0; res_sat = 1'b0;
        end else begin
            take = valid_i && model_ready();
            if (has_res && ready_i) has_res = 1'b0;
            if (take) begin
                grp_sum += longint'($signed(prod_i));
                grp_n++;
                if (grp_n == NT) begin
                    res     = clamp(rnd_shift(grp_sum));
                    res_sat = is_sat(rnd_shift(grp_sum));
                    has_res = 1'b1;
                    grp_sum = 0;
                    grp_n   = 0;
                end
            end
        end
    end

    // Compare every cycle, mid-period, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready_o", longint'(ready_o), longint'(model_ready()));
            chk("valid_o", longint'(valid_o), longint'(has_res));
            chk("sum_o", longint'($signed(sum_o)), res);
            chk("sat_o", longint'(sat_o), longint'(res_sat));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] p);
        valid_i = 1'b1;
        prod_i  = p;
        step();
        valid_i = 1'b0;
    endtask

    // Three terms with ready_i high; result must show right after the third.
    task automatic group3(input string name, input logic [IW-1:0] a,
                          input logic [IW-1:0] b, input logic [IW-1:0] c,
                          input longint exp_sum, input bit exp_sat);
        ready_i = 1'b1;
        send(a); send(b); send(c);
        chk({name, "_valid"}, longint'(valid_o), 1);
        chk({name, "_sum"}, longint'($signed(sum_o)), exp_sum);
        chk({name, "_sat"}, longint'(sat_o), longint'(exp_sat));
        chk({name, "_ready"}, longint'(ready_o), 1);
        step();  // result consumed
    endtask

    initial begin
        // pin the model itself with hand-computed values
        chk("model_rnd_p180", clamp(rnd_shift(64'sh180)), 2);
        chk("model_rnd_m180", clamp(rnd_shift(-64'sh180)), -1);
        chk("model_rnd_17f", clamp(rnd_shift(64'sh17F)), 1);
        chk("model_sat_pos", clamp(rnd_shift(64'sh0300_0000)), 32767);
        chk("model_sat_neg", clamp(rnd_shift(-64'sh0300_0000)), -32768);

        reset_i = 1'b0;
        step(); step();
        chk("reset_valid", longint'(valid_o), 0);
        chk("reset_sum", longint'(sum_o), 0);
        chk("reset_sat", longint'(sat_o), 0);
        chk("reset_ready", longint'(ready_o), 0);
        reset_i = 1'b1;
        #1;
        cmp_en = 1'b1;

        // 1. defaults
        group3("basic", 32'h100, 32'h200, 32'h300, 6, 1'b0);
        // 2. rounding
        group3("rnd_p180", 32'h80, 32'h80, 32'h80, 2, 1'b0);
        group3("rnd_m180", -32'sh80, -32'sh80, -32'sh80, -1, 1'b0);
        group3("rnd_17f", 32'h7F, 32'h80, 32'h80, 1, 1'b0);
        // 3. saturation
        group3("sat_pos", 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32767, 1'b1);
        group3("sat_neg", -32'sh0100_0000, -32'sh0100_0000, -32'sh0100_0000, -32768, 1'b1);

        // 4. backpressure: hold result 5 cycles with a term waiting
        ready_i = 1'b1;
        send(32'h100); send(32'h100);
        ready_i = 1'b0;
        send(32'h100);
        valid_i = 1'b1;
        prod_i  = 32'h400;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", longint'(valid_o), 1);
            chk("bp_sum", longint'($signed(sum_o)), 3);
            chk("bp_ready", longint'(ready_o), 0);
            step();
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_ready", longint'(ready_o), 1);
        step();  // consume + accept 0x400 as term 0
        valid_i = 1'b0;
        chk("bp_consumed", longint'(valid_o), 0);
        send(32'h100); send(32'h100);
        chk("bp_next_sum", longint'($signed(sum_o)), 6);
        step();

        // 5. streaming 1..9 <<8 back to back
        ready_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            chk("stream_ready", longint'(ready_o), 1);
            valid_i = 1'b1;
            prod_i  = IW'(k << 8);
            step();
            chk("stream_valid", longint'(valid_o), (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0)
                chk("stream_sum", longint'($signed(sum_o)), 3 * k - 3);
        end
        valid_i = 1'b0;
        step();

        // 6a. reset mid-group discards terms
        send(32'h500); send(32'h500);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        group3("rst_mid", 32'h100, 32'h100, 32'h100, 3, 1'b0);
        // 6b. reset while holding a result
        ready_i = 1'b0;
        send(32'h100); send(32'h100); send(32'h100);
        chk("rst_hold_valid", longint'(valid_o), 1);
        reset_i = 1'b0;
        step();
        chk("rst_out_valid", longint'(valid_o), 0);
        chk("rst_out_sum", longint'(sum_o), 0);
        reset_i = 1'b1;
        ready_i = 1'b1;
        step();

        // random traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            reset_i = ($urandom_range(0, 199) != 0);
            case ($urandom_range(0, 2))
                0: prod_i = IW'($urandom_range(0, 1023)) - IW'(512);
                1: prod_i = $urandom;
                default: prod_i = IW'($urandom_range(0, 32'h00FF_FFFF)) - IW'(32'h0080_0000);
            endcase
            step();
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
